// File: rtl/bus_port_pkg.sv
// Shared types and helpers for the per-device bus port: destination ID
// extraction and the saturating drop-counter type.
package bus_port_pkg;

   localparam int ID_W    = 8;
   localparam int PKT_MAX = 64;

   typedef logic [7:0] sat_cnt_t;

   // Packet is passed zero-extended to PKT_MAX; w is the real packet width.
   function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt,
                                                input int unsigned       w);
      return ID_W'(pkt >> (w - ID_W));
   endfunction

   function automatic sat_cnt_t sat_inc(input sat_cnt_t c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers. A read and a write in
// the same cycle are both honoured, even when the FIFO is full.
module sync_fifo #(
   parameter int width = 16,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [width-1:0] din,
   input  logic             rd,
   output logic [width-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [width-1:0] mem [depth];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             rd_en;
   logic             wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A read in the same cycle frees the slot a full-FIFO write needs.
   assign rd_en = rd && !empty;
   assign wr_en = wr && (!full || rd_en);

   assign dout = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/bus_dev_port.sv
// Per-device bus front end: TX FIFO toward the arbiter, destination-filtered
// RX FIFO toward the device, and saturating drop counters.
module bus_dev_port
   import bus_port_pkg::*;
#(
   parameter int            pckg_sz   = 16,
   parameter int            depth     = 4,
   parameter logic [7:0]    id        = 8'd0,
   parameter logic [7:0]    broadcast = 8'hFF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               dev_wr,
   input  logic [pckg_sz-1:0] dev_din,
   output logic               dev_full,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   input  logic               dev_rd,
   output logic [pckg_sz-1:0] dev_dout,
   output logic               dev_rx_vld,
   output sat_cnt_t           ovf_cnt,
   output sat_cnt_t           mis_cnt
);

   // Handshakes: a transfer happens at a posedge where the consumer strobe
   // (pop / dev_rd) is high while the producer flag (pndng / dev_rx_vld) is
   // high; strobes against an empty side are ignored. push has no ready and
   // is always sampled.

   logic [pckg_sz-1:0] tx_dout;
   logic               tx_empty;
   logic [pckg_sz-1:0] rx_dout;
   logic               rx_empty;
   logic               rx_full;
   logic [ID_W-1:0]    dest;
   logic               dest_ok;
   logic               rx_wr;
   logic               ovf_inc;
   logic               mis_inc;

   sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (dev_wr),
      .din   (dev_din),
      .rd    (pop),
      .dout  (tx_dout),
      .full  (dev_full),
      .empty (tx_empty)
   );

   assign dest    = dest_of(PKT_MAX'(D_push), pckg_sz);
   assign dest_ok = (dest == id) || (dest == broadcast);
   assign rx_wr   = push && dest_ok;
   // A full RX only overflows if the device is not reading in the same cycle.
   assign ovf_inc = rx_wr && rx_full && !dev_rd;
   assign mis_inc = push && !dest_ok;

   sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (rx_wr),
      .din   (D_push),
      .rd    (dev_rd),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign pndng      = !tx_empty;
   assign D_pop      = tx_empty ? '0 : tx_dout;
   assign dev_rx_vld = !rx_empty;
   assign dev_dout   = rx_empty ? '0 : rx_dout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_cnt <= '0;
         mis_cnt <= '0;
      end else begin
         if (ovf_inc) ovf_cnt <= sat_inc(ovf_cnt);
         if (mis_inc) mis_cnt <= sat_inc(mis_cnt);
      end
   end

endmodule

// File: tb/tb_bus_dev_port.sv
// Bench for bus_dev_port: directed scenarios plus random traffic, checked
// against a queue-level model of both FIFOs and the drop counters.
module tb_bus_dev_port;

   localparam int         PW    = 16;
   localparam int         DEPTH = 4;
   localparam logic [7:0] MY_ID = 8'h02;

   logic          clk = 1'b0;
   logic          reset;
   logic          dev_wr;
   logic [PW-1:0] dev_din;
   logic          dev_full;
   logic          pndng;
   logic [PW-1:0] D_pop;
   logic          pop;
   logic          push;
   logic [PW-1:0] D_push;
   logic          dev_rd;
   logic [PW-1:0] dev_dout;
   logic          dev_rx_vld;
   logic [7:0]    ovf_cnt;
   logic [7:0]    mis_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: plain queues and counters.
   logic [PW-1:0] txq[$];
   logic [PW-1:0] rxq[$];
   int            ovf_m;
   int            mis_m;

   bus_dev_port #(.pckg_sz(PW), .depth(DEPTH), .id(MY_ID), .broadcast(8'hFF)) dut (
      .clk        (clk),
      .reset      (reset),
      .dev_wr     (dev_wr),
      .dev_din    (dev_din),
      .dev_full   (dev_full),
      .pndng      (pndng),
      .D_pop      (D_pop),
      .pop        (pop),
      .push       (push),
      .D_push     (D_push),
      .dev_rd     (dev_rd),
      .dev_dout   (dev_dout),
      .dev_rx_vld (dev_rx_vld),
      .ovf_cnt    (ovf_cnt),
      .mis_cnt    (mis_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      txq.delete();
      rxq.delete();
      ovf_m = 0;
      mis_m = 0;
   endtask

   task automatic model_step(input logic wr, input logic [PW-1:0] din, input logic p,
                             input logic ps, input logic [PW-1:0] dp, input logic rd);
      logic [7:0] dst;
      if (p && txq.size() > 0) void'(txq.pop_front());
      if (wr && txq.size() < DEPTH) txq.push_back(din);
      if (rd && rxq.size() > 0) void'(rxq.pop_front());
      if (ps) begin
         dst = dp[PW-1 -: 8];
         if (dst == MY_ID || dst == 8'hFF) begin
            if (rxq.size() < DEPTH) rxq.push_back(dp);
            else if (ovf_m < 255) ovf_m++;
         end else if (mis_m < 255) mis_m++;
      end
   endtask

   task automatic check_all();
      check("dev_full",   32'(dev_full),   32'(txq.size() == DEPTH));
      check("pndng",      32'(pndng),      32'(txq.size() > 0));
      check("D_pop",      32'(D_pop),      txq.size() > 0 ? 32'(txq[0]) : 32'h0);
      check("dev_rx_vld", 32'(dev_rx_vld), 32'(rxq.size() > 0));
      check("dev_dout",   32'(dev_dout),   rxq.size() > 0 ? 32'(rxq[0]) : 32'h0);
      check("ovf_cnt",    32'(ovf_cnt),    32'(ovf_m));
      check("mis_cnt",    32'(mis_cnt),    32'(mis_m));
   endtask

   // Called just after a negedge: drive, advance model, sample at next negedge.
   task automatic step(input logic wr, input logic [PW-1:0] din, input logic p,
                       input logic ps, input logic [PW-1:0] dp, input logic rd);
      dev_wr = wr; dev_din = din; pop = p; push = ps; D_push = dp; dev_rd = rd;
      model_step(wr, din, p, ps, dp, rd);
      @(posedge clk);
      @(negedge clk);
      check_all();
      dev_wr = 1'b0; pop = 1'b0; push = 1'b0; dev_rd = 1'b0;
   endtask

   task automatic tx_write(input logic [PW-1:0] d);
      step(1'b1, d, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic tx_pop();
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic rx_push(input logic [PW-1:0] d);
      step(1'b0, '0, 1'b0, 1'b1, d, 1'b0);
   endtask

   task automatic rx_read();
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      logic [7:0]    dsel;
      logic [PW-1:0] pkt;

      // Reset held with dev_wr asserted: nothing may be captured.
      reset = 1'b0; dev_wr = 1'b1; dev_din = 16'h1234;
      pop = 1'b0; push = 1'b0; D_push = '0; dev_rd = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      check("rst_pndng", 32'(pndng), 32'h0);
      check("rst_D_pop", 32'(D_pop), 32'h0);
      check("rst_ovf",   32'(ovf_cnt), 32'h0);
      check("rst_mis",   32'(mis_cnt), 32'h0);
      check_all();
      reset = 1'b1; dev_wr = 1'b0;

      tx_write(16'h0311);
      check("first_pndng", 32'(pndng), 32'h1);
      check("first_D_pop", 32'(D_pop), 32'h0311);
      tx_pop();

      // TX fill, dropped 5th write, ordered drain.
      for (int i = 1; i <= 4; i++) tx_write(16'h0100 + 16'(i));
      check("tx_full", 32'(dev_full), 32'h1);
      tx_write(16'h0105);
      for (int i = 1; i <= 4; i++) begin
         check("tx_order", 32'(D_pop), 32'(16'h0100 + 16'(i)));
         tx_pop();
      end
      check("tx_drained", 32'(pndng), 32'h0);
      tx_pop();

      // Write + pop on a full TX FIFO.
      for (int i = 1; i <= 4; i++) tx_write(16'h0200 + 16'(i));
      step(1'b1, 16'h0AAA, 1'b1, 1'b0, '0, 1'b0);
      check("tx_full_wrpop", 32'(dev_full), 32'h1);
      repeat (3) tx_pop();
      check("tx_last_0aaa", 32'(D_pop), 32'h0AAA);
      tx_pop();

      // Write + pop with a single entry.
      tx_write(16'h0C01);
      step(1'b1, 16'h0C02, 1'b1, 1'b0, '0, 1'b0);
      check("tx_one_pndng", 32'(pndng), 32'h1);
      check("tx_one_head",  32'(D_pop), 32'h0C02);
      tx_pop();

      // RX destination filter.
      rx_push(16'h0255);
      check("rx_first_dout", 32'(dev_dout), 32'h0255);
      rx_push(16'hFF66);
      rx_push(16'h0377);
      check("rx_mis1", 32'(mis_cnt), 32'h1);
      rx_read();
      check("rx_bcast", 32'(dev_dout), 32'hFF66);
      rx_read();
      check("rx_empty", 32'(dev_rx_vld), 32'h0);
      rx_read();

      // RX overflow, then push + read on full.
      for (int i = 1; i <= 6; i++) rx_push(16'h0200 + 16'(i));
      check("rx_ovf2", 32'(ovf_cnt), 32'h2);
      check("rx_head", 32'(dev_dout), 32'h0201);
      step(1'b0, '0, 1'b0, 1'b1, 16'h02EE, 1'b1);
      check("rx_ovf_hold", 32'(ovf_cnt), 32'h2);
      check("rx_full_rdwr", 32'(dev_dout), 32'h0202);
      repeat (4) rx_read();

      // Mismatch counter saturation.
      for (int i = 0; i < 260; i++) rx_push(16'h0500 + 16'(i % 256));
      check("mis_sat", 32'(mis_cnt), 32'hFF);

      // Async reset between edges with both FIFOs holding data.
      tx_write(16'h0D01);
      tx_write(16'h0D02);
      rx_push(16'h02D3);
      #2 reset = 1'b0;
      #1;
      check("arst_pndng",  32'(pndng),      32'h0);
      check("arst_D_pop",  32'(D_pop),      32'h0);
      check("arst_rxvld",  32'(dev_rx_vld), 32'h0);
      check("arst_dout",   32'(dev_dout),   32'h0);
      check("arst_mis",    32'(mis_cnt),    32'h0);
      check("arst_full",   32'(dev_full),   32'h0);
      model_clear();
      @(negedge clk);
      check_all();
      reset = 1'b1;

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 3))
            0:       dsel = MY_ID;
            1:       dsel = 8'hFF;
            default: dsel = 8'($urandom_range(0, 255));
         endcase
         pkt = {dsel, 8'($urandom_range(0, 255))};
         step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), pkt,
              1'($urandom_range(0, 2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
